simple_memory_initiator: RTL and testbench
==========================================

Name: simple_memory_initiator

Overview:
- Initiator (requester) side of the simple_memory port; drives `we`/`re`/`addr`/`din` and consumes `dout`.
- Accepts burst commands over a valid/ready handshake and accepts a write-data stream.
- Sequences single-beat accesses with incrementing, wrapping addresses.
- Returns read data as a valid-qualified stream.
- Sits between a host/test sequencer and one simple_memory instance.

Parameters:
- ADDR_W, 3, address width; memory depth is 2**ADDR_W.
- DATA_W, 8, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  beats minus 1 (range 1..2**ADDR_W beats).
- wdata_valid  in  1  write beat available.
- wdata_ready  out  1  write beat accepted when both high at an edge.
- wdata  in  DATA_W  write beat data.
- rdata_valid  out  1  one-cycle qualifier per read beat; no backpressure.
- rdata  out  DATA_W  read beat data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at burst completion.
- mem_we  out  1  to memory `we`.
- mem_re  out  1  to memory `re`.
- mem_addr  out  ADDR_W  to memory `addr`.
- mem_din  out  DATA_W  to memory `din`.
- mem_dout  in  DATA_W  from memory `dout`.

Behaviour:
- Memory contract:
  - Write: memory writes `din` to `addr` at the edge where `we` is sampled high.
  - Read: `dout` is valid in the cycle after the edge where `re` is sampled high (1-cycle registered read).
- Reset (rst_n low, asynchronous): state = IDLE.
  - cmd_ready = 1; all other outputs = 0.
  - Beat counter and address register = 0.
- All mem_* outputs, rdata, rdata_valid and done are registered.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On handshake: latch cmd_addr into cur_addr, cmd_len into remaining, cmd_write into op.
  - op = 1 → WRITE; op = 0 → READ.
- WRITE:
  - wdata_ready = 1 while remaining beats > 0.
  - Beat accepted at edge k → during cycle k+1: mem_we = 1, mem_addr = cur_addr, mem_din = wdata.
  - Then cur_addr += 1 (mod 2**ADDR_W).
  - Stalls (wdata_valid low) hold mem_we = 0; there are no bubbles otherwise.
  - After the last beat is accepted: DRAIN.
- READ:
  - Each cycle: mem_re = 1, mem_addr = cur_addr, cur_addr += 1, remaining -= 1.
  - After the last issue: DRAIN.
- Read return path:
  - mem_re high in cycle k → block samples mem_dout at edge k+2.
  - rdata_valid = 1 and rdata = sampled value in cycle k+2.
  - Total latency from issue to rdata_valid is 2 cycles; throughput is 1 beat/cycle.
- DRAIN:
  - mem_we = 0, mem_re = 0.
  - Write op: done = 1 in the cycle after the last mem_we cycle, then IDLE.
  - Read op: done = 1 coincident with the last rdata_valid, then IDLE.
  - cmd_ready rises in the cycle after done.
- Boundaries:
  - Address wrap: start 6, 4 beats → addresses 6, 7, 0, 1.
  - Full-depth burst: cmd_len = all-ones → 2**ADDR_W beats, visiting every address exactly once.
  - Single beat: cmd_len = 0 → exactly 1 access.
  - Busy: cmd_ready is 0 outside IDLE; cmd_valid is ignored and the command is not latched.
  - mem_we and mem_re are never high in the same cycle.
  - wdata_valid outside WRITE is ignored.
  - Reset mid-burst: immediate return to reset values; in-flight beats are dropped; no done pulse; memory contents are unspecified for the aborted beat.

Optional Feature:
- Macro: SIMPLE_MEMORY_INITIATOR_CLEAR_EN.
- Defined:
  - Reset enters a CLEAR state instead of IDLE.
  - CLEAR writes 0 to addresses 0..2**ADDR_W-1, one per cycle (mem_we = 1).
  - busy = 1 and cmd_ready = 0 throughout CLEAR.
  - One done pulse after the final clear write, then IDLE.
- Undefined:
  - No CLEAR state; reset goes directly to IDLE and memory contents are untouched.

Test Plan:
- Write burst: addr 2, len 0 (1 beat), wdata A5 → one cycle mem_we = 1, mem_addr = 2, mem_din = A5; done one cycle later. Read addr 2, len 0 → rdata_valid with rdata = A5, 2 cycles after mem_re; done coincident.
- Wrap: write addr 6, len 3, data 11, 22, 33, 44 → mem_addr sequence 6, 7, 0, 1. Read back the same range → rdata 11, 22, 33, 44 on consecutive cycles.
- Backpressure: wdata_valid toggled 1,0,0,1 on a 2-beat write → mem_we only in the cycles after each accepted beat; exactly 2 writes; done after the second.
- Busy rejection: assert cmd_valid during a 4-beat read → cmd_ready = 0 throughout and the second command is not executed; cmd_ready = 1 the cycle after done.
- Reset mid-burst: deassert rst_n during beat 3 of an 8-beat write → all outputs 0 immediately, no done; a new read command is accepted after release.
- With SIMPLE_MEMORY_INITIATOR_CLEAR_EN: preload memory with FF → after reset, 8 writes of 00 to addresses 0..7, cmd_ready = 0 throughout, then a full-depth read returns eight 00 beats.

Source files
------------

// File: rtl/simple_memory_initiator.sv
// Burst initiator for one single-port memory with a 1-cycle registered read.
// Define SIMPLE_MEMORY_INITIATOR_CLEAR_EN to zero every memory location after each reset.
module simple_memory_initiator #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3
`ifdef SIMPLE_MEMORY_INITIATOR_CLEAR_EN
    , CLEAR = 3'd4
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONES = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

`ifdef SIMPLE_MEMORY_INITIATOR_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
  localparam logic   RESET_OP    = 1'b1;
`else
  localparam state_t RESET_STATE = IDLE;
  localparam logic   RESET_OP    = 1'b0;
`endif

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] cur_addr_r, cur_addr_s;
  logic [ADDR_W-1:0] remaining_r, remaining_s;
  logic              op_r, op_s;
  logic              mem_we_r, mem_we_s;
  logic              mem_re_r, mem_re_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_din_r, mem_din_s;
  logic              done_r, done_s;
  logic              rd_pend_r;
  logic              rdata_valid_r;
  logic [DATA_W-1:0] rdata_r;

  // Next-state and next-register computation for the burst sequencer.
  always_comb begin
    state_s     = state_r;
    cur_addr_s  = cur_addr_r;
    remaining_s = remaining_r;
    op_s        = op_r;
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_din_s   = mem_din_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_s  = cmd_addr;
          remaining_s = cmd_len;
          op_s        = cmd_write;
          state_s     = cmd_write ? WRITE : READ;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          mem_we_s   = 1'b1;
          mem_addr_s = cur_addr_r;
          mem_din_s  = wdata;
          cur_addr_s = cur_addr_r + ADDR_ONE;
          if (remaining_r == ADDR_ZERO) begin
            state_s = DRAIN;
          end else begin
            remaining_s = remaining_r - ADDR_ONE;
          end
        end else begin
          state_s = WRITE;
        end
      end
      READ: begin
        mem_re_s   = 1'b1;
        mem_addr_s = cur_addr_r;
        cur_addr_s = cur_addr_r + ADDR_ONE;
        if (remaining_r == ADDR_ZERO) begin
          state_s = DRAIN;
        end else begin
          remaining_s = remaining_r - ADDR_ONE;
        end
      end
      DRAIN: begin
        // Writes finish one cycle after the last mem_we; reads finish with the last returned beat.
        if (done_r) begin
          state_s = IDLE;
        end else if (op_r ? mem_we_r : (rd_pend_r && !mem_re_r)) begin
          done_s = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
`ifdef SIMPLE_MEMORY_INITIATOR_CLEAR_EN
      CLEAR: begin
        mem_we_s   = 1'b1;
        mem_addr_s = cur_addr_r;
        mem_din_s  = DATA_ZERO;
        cur_addr_s = cur_addr_r + ADDR_ONE;
        if (cur_addr_r == ADDR_ONES) begin
          state_s = DRAIN;
        end else begin
          state_s = CLEAR;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RESET_STATE;
      cur_addr_r  <= ADDR_ZERO;
      remaining_r <= ADDR_ZERO;
      op_r        <= RESET_OP;
      mem_we_r    <= 1'b0;
      mem_re_r    <= 1'b0;
      mem_addr_r  <= ADDR_ZERO;
      mem_din_r   <= DATA_ZERO;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_addr_r  <= cur_addr_s;
      remaining_r <= remaining_s;
      op_r        <= op_s;
      mem_we_r    <= mem_we_s;
      mem_re_r    <= mem_re_s;
      mem_addr_r  <= mem_addr_s;
      mem_din_r   <= mem_din_s;
      done_r      <= done_s;
    end
  end

  // Read return pipe: dout is valid the cycle after the memory samples re.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r     <= 1'b0;
      rdata_valid_r <= 1'b0;
      rdata_r       <= DATA_ZERO;
    end else begin
      rd_pend_r     <= mem_re_r;
      rdata_valid_r <= rd_pend_r;
      if (rd_pend_r) begin
        rdata_r <= mem_dout;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign cmd_ready   = (state_r == IDLE);
  assign wdata_ready = (state_r == WRITE);
  assign busy        = (state_r != IDLE);
  assign done        = done_r;
  assign mem_we      = mem_we_r;
  assign mem_re      = mem_re_r;
  assign mem_addr    = mem_addr_r;
  assign mem_din     = mem_din_r;
  assign rdata_valid = rdata_valid_r;
  assign rdata       = rdata_r;

endmodule

// File: tb/tb_simple_memory_initiator.sv
// Self-checking bench for simple_memory_initiator with a behavioural memory and reference image.
// Honours SIMPLE_MEMORY_INITIATOR_CLEAR_EN to expect the post-reset clear sweep.
module tb_simple_memory_initiator;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              wdata_valid = 1'b0;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata = '0;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simple_memory_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy), .done(done),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Behavioural simple_memory: write on we edge, registered read data one cycle after re.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              fill_req = 1'b0;
  logic [DATA_W-1:0] fill_val = '0;
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= fill_val;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_din;
      if (mem_re) mem_dout <= mem[mem_addr];
    end
  end

  // Reference image of what the memory should hold.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                ref_known [DEPTH];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                c;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ev_t;
  ev_t wr_q[$];
  ev_t rd_q[$];
  ev_t rv_q[$];
  int  done_q[$];

  // Bus monitor: logs every memory access, returned beat and done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) wr_q.push_back('{cyc, mem_addr, mem_din});
      if (mem_re) rd_q.push_back('{cyc, mem_addr, 8'h00});
      if (rdata_valid) rv_q.push_back('{cyc, 3'd0, rdata});
      if (done) done_q.push_back(cyc);
      checks++;
      assert (!(mem_we && mem_re)) else begin
        errors++;
        $error("FAIL we_re_exclusive: observed we=%0b re=%0b required not both", mem_we, mem_re);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wr_q.delete(); rd_q.delete(); rv_q.delete(); done_q.delete();
  endtask

  task automatic reset_checks(input string tag);
`ifdef SIMPLE_MEMORY_INITIATOR_CLEAR_EN
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_busy"}, busy, 1);
`else
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
`endif
    chk({tag, "_wdata_ready"}, wdata_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdata_valid"}, rdata_valid, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_re"}, mem_re, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_din"}, mem_din, 0);
  endtask

  task automatic issue(input bit w, input int a, input int l);
    int t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a[ADDR_W-1:0]; cmd_len = l[ADDR_W-1:0];
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input int stall);
    int t = 0;
    wdata_valid = 1'b0;
    repeat (stall) @(negedge clk);
    wdata_valid = 1'b1; wdata = d;
    while (!wdata_ready && t < 50) begin @(negedge clk); t++; end
    chk("wdata_ready_wait", wdata_ready, 1);
    @(negedge clk);
    wdata_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit chk_busy);
    int t = 0;
    while (done !== 1'b1 && t < 200) begin
      if (chk_busy) chk({tag, "_cmd_ready_busy"}, cmd_ready, 0);
      @(negedge clk); t++;
    end
    if (chk_busy) chk({tag, "_cmd_ready_at_done"}, cmd_ready, 0);
    chk({tag, "_done"}, done, 1);
    cmd_valid = 1'b0; wdata_valid = 1'b0;
    #1;
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, "_cmd_ready_after"}, cmd_ready, 1);
    chk({tag, "_done_pulse_width"}, done, 0);
  endtask

  task automatic write_burst(input string tag, input int a, input int l,
                             input logic [DATA_W-1:0] d[$], input int st[$]);
    int n = l + 1;
    clear_q();
    issue(1'b1, a, l);
    for (int i = 0; i < n; i++) send_beat(d[i], (i < st.size()) ? st[i] : 0);
    wait_done(tag, 1'b0);
    chk({tag, "_nwrites"}, wr_q.size(), n);
    chk({tag, "_nreads"}, rd_q.size(), 0);
    chk({tag, "_ndone"}, done_q.size(), 1);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_q[i].a, (a + i) % DEPTH);
      chk($sformatf("%s_data%0d", tag, i), wr_q[i].d, d[i]);
      if (i > 0)
        chk($sformatf("%s_gap%0d", tag, i), wr_q[i].c - wr_q[i-1].c,
            ((i < st.size()) ? st[i] : 0) + 1);
      ref_mem[(a + i) % DEPTH] = d[i];
      ref_known[(a + i) % DEPTH] = 1'b1;
    end
    chk({tag, "_done_lat"}, done_q[0], wr_q[n-1].c + 1);
    after_done(tag);
  endtask

  task automatic read_burst(input string tag, input int a, input int l, input bit hold);
    int n = l + 1;
    clear_q();
    issue(1'b0, a, l);
    if (hold) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd0; cmd_len = 3'd0;
      wdata_valid = 1'b1; wdata = 8'hEE;
    end
    wait_done(tag, hold);
    chk({tag, "_nreads"}, rd_q.size(), n);
    chk({tag, "_nbeats"}, rv_q.size(), n);
    chk({tag, "_nwrites"}, wr_q.size(), 0);
    chk({tag, "_ndone"}, done_q.size(), 1);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), rd_q[i].a, (a + i) % DEPTH);
      chk($sformatf("%s_lat%0d", tag, i), rv_q[i].c, rd_q[i].c + 2);
      if (i > 0) chk($sformatf("%s_issue_gap%0d", tag, i), rd_q[i].c - rd_q[i-1].c, 1);
      if (ref_known[(a + i) % DEPTH])
        chk($sformatf("%s_data%0d", tag, i), rv_q[i].d, ref_mem[(a + i) % DEPTH]);
    end
    chk({tag, "_done_coincident"}, done_q[0], rv_q[n-1].c);
    after_done(tag);
    if (hold) begin
      repeat (3) @(negedge clk);
      chk({tag, "_rejected_busy"}, busy, 0);
      chk({tag, "_rejected_writes"}, wr_q.size(), 0);
    end
  endtask

`ifdef SIMPLE_MEMORY_INITIATOR_CLEAR_EN
  task automatic clear_sweep(input string tag);
    wait_done(tag, 1'b1);
    chk({tag, "_nwrites"}, wr_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_q[i].a, i);
      chk($sformatf("%s_data%0d", tag, i), wr_q[i].d, 0);
      ref_mem[i] = '0;
      ref_known[i] = 1'b1;
    end
    after_done(tag);
  endtask
`endif

  logic [DATA_W-1:0] dq[$];
  int                sq[$];

  initial begin
    fill_req = 1'b1; fill_val = 8'hFF;
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = 8'hFF; ref_known[i] = 1'b1; end
    @(negedge clk); @(negedge clk);
    fill_req = 1'b0;
    reset_checks("reset");
    clear_q();
    rst_n = 1'b1;
`ifdef SIMPLE_MEMORY_INITIATOR_CLEAR_EN
    clear_sweep("clear");
    read_burst("clear_rd", 0, 7, 1'b0);
`else
    @(negedge clk);
`endif

    dq = {8'hA5}; sq = {0};
    write_burst("wr1", 2, 0, dq, sq);
    read_burst("rd1", 2, 0, 1'b0);

    dq = {8'h11, 8'h22, 8'h33, 8'h44}; sq = {0, 0, 0, 0};
    write_burst("wrap", 6, 3, dq, sq);
    read_burst("wrap_rd", 6, 3, 1'b0);

    dq = {8'hC3, 8'h3C}; sq = {0, 2};
    write_burst("bp", 0, 1, dq, sq);

    read_burst("busy", 0, 3, 1'b1);

    // Abort an 8-beat write while its third beat is on the memory bus.
    clear_q();
    issue(1'b1, 3, 7);
    send_beat(8'h71, 0);
    send_beat(8'h72, 0);
    wdata_valid = 1'b1; wdata = 8'h73;
    @(negedge clk);
    chk("abort_we_before", mem_we, 1);
    rst_n = 1'b0; wdata_valid = 1'b0;
    #1;
    reset_checks("abort");
    ref_mem[3] = 8'h71; ref_mem[4] = 8'h72; ref_known[5] = 1'b0;
    @(negedge clk); @(negedge clk);
    clear_q();
    rst_n = 1'b1;
`ifdef SIMPLE_MEMORY_INITIATOR_CLEAR_EN
    clear_sweep("abort_clear");
`else
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_q.size(), 0);
    chk("abort_idle", busy, 0);
    read_burst("abort_rd", 3, 1, 1'b0);
`endif

    dq.delete(); sq.delete();
    for (int i = 0; i < DEPTH; i++) begin dq.push_back(8'($urandom_range(0, 255))); sq.push_back(0); end
    write_burst("full", 5, 7, dq, sq);
    read_burst("full_rd", 5, 7, 1'b0);

    for (int k = 0; k < 24; k++) begin
      int a = $urandom_range(0, DEPTH - 1);
      int l = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) begin
        dq.delete(); sq.delete();
        for (int i = 0; i <= l; i++) begin
          dq.push_back(8'($urandom_range(0, 255)));
          sq.push_back($urandom_range(0, 2));
        end
        write_burst($sformatf("rw%0d", k), a, l, dq, sq);
      end else begin
        read_burst($sformatf("rr%0d", k), a, l, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
